id_stage: RTL
=============

Name: id_stage

Overview:
- Decode stage of the 5-stage word-addressed pipeline. Consumes PC and Instruction from the IF stage registers and feeds the ID/EXE stage registers.
- Contains the 32x32 register file, the instruction decoder and the hazard detector.
- Resolves branches here: drives branch-taken and branch-target back to IF, plus the flush consumed by the IF stage registers.

Parameters:
- REG_COUNT, 32, register-file depth; register 0 is hardwired to zero.
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- PC_in  in  32  PC+1 of the instruction, from the IF registers
- Instruction  in  32  instruction word; fields: op[31:26] dest[25:21] src1[20:16] src2[15:11] imm[15:0]
- WB_En_in  in  1  writeback enable
- WB_Dest_in  in  5  writeback address
- WB_Value  in  32  writeback data
- EXE_Dest  in  5  destination of the instruction in EXE
- EXE_WB_En  in  1  writeback enable of the instruction in EXE
- EXE_MEM_R_En  in  1  the instruction in EXE is a load
- MEM_Dest  in  5  destination of the instruction in MEM
- MEM_WB_En  in  1  writeback enable of the instruction in MEM
- Val1  out  32  reg[src1]
- Val2  out  32  reg[src2] for R-type; sext(imm) otherwise
- Reg2  out  32  store data / second branch operand, reg[dest]
- Dest  out  5  destination field
- Src1  out  5  hazard/forwarding source address
- Src2  out  5  hazard/forwarding source address
- EXE_CMD  out  4  ALU operation
- MEM_R_En  out  1  load
- MEM_W_En  out  1  store
- WB_En  out  1  writeback
- Br_taken  out  1  redirect IF and flush the IF registers
- Br_target  out  32  PC_in + sext(imm)
- hazard_stall  out  1  freeze PC and the IF registers; insert a bubble

Behaviour:
- Opcodes and EXE_CMD:
  - NOP 0
  - ADD 1 = 0000, SUB 3 = 0010, AND 5 = 0100, OR 6 = 0101, NOR 7 = 0110, XOR 8 = 0111
  - SLA 9 and SLL 10 = 1000, SRA 11 = 1001, SRL 12 = 1010
  - ADDI 32 = 0000, SUBI 33 = 0010
  - LD 36 = 0000, ST 37 = 0000
  - BEZ 40, BNE 41, JMP 42
  - Any undefined opcode decodes as NOP.
- Register file: write at posedge clk when WB_En_in=1 and WB_Dest_in!=0. Writes to register 0 are ignored; reads of register 0 return 0.
- Read bypass: a read whose address equals WB_Dest_in while WB_En_in=1 (address !=0) returns WB_Value in the same cycle.
- Reset: rst at posedge clears all registers to 0. While rst=1, all control outputs, Br_taken and hazard_stall are 0, and EXE_CMD=0. Reset is honoured mid-stall.
- Read-port addressing:
  - Port 1 address = src1.
  - Port 2 address = dest for ST and BNE, src2 otherwise.
  - Src2 output = port 2 address.
- Control signals:
  - WB_En=1 for R-type, ADDI/SUBI and LD.
  - MEM_R_En=1 for LD only; MEM_W_En=1 for ST only.
- Source usage:
  - src1 is used by all opcodes except NOP and JMP.
  - The second source is used by R-type, ST and BNE only.
- Branches (all combinational, latency 0):
  - BEZ is taken if Val1==0.
  - BNE is taken if reg[src1]!=reg[dest].
  - JMP is always taken.
  - Br_target is 32-bit wrap-around addition.
- Hazard: hazard_stall=1 when a used source (nonzero address) equals EXE_Dest with EXE_WB_En=1, or equals MEM_Dest with MEM_WB_En=1. See the optional feature below.
- While hazard_stall=1:
  - WB_En, MEM_R_En, MEM_W_En and Br_taken are forced to 0 (bubble).
  - Datapath outputs remain valid.
- A simultaneous writeback to the stalled source resolves through the bypass on the next cycle, once EXE and MEM have advanced.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: hazard_stall is raised only for load-use, i.e. a used source equals EXE_Dest with EXE_MEM_R_En=1. MEM and non-load EXE dependencies are left to the forwarding unit.
- Undefined: the full RAW check above applies.

Test Plan:
- rst=1 for 2 cycles, then read all registers via ADD r1, r2, r3 -> Val1=Val2=0; outputs 0 during rst.
- WB_En_in=1, WB_Dest_in=5, WB_Value=0xDEADBEEF with Instruction ADD dest=1, src1=5 in the same cycle -> Val1=0xDEADBEEF (bypass); the value persists the next cycle. A write to register 0 leaves reads at 0.
- ADDI with imm=0xFFFE -> Val2=0xFFFFFFFE, EXE_CMD=0000, WB_En=1.
- BEZ with reg[src1]=0, PC_in=0x10, imm=0xFFFC -> Br_taken=1, Br_target=0x0C. Same with reg[src1]=7 -> Br_taken=0.
- EXE_Dest=4, EXE_WB_En=1, EXE_MEM_R_En=0, instruction SUB src1=4:
  - FORWARDING_EN undefined -> hazard_stall=1, WB_En=0.
  - FORWARDING_EN defined -> hazard_stall=0.
  - With EXE_MEM_R_En=1 -> hazard_stall=1 in both builds.
- ST with dest=9, EXE_Dest=9, EXE_WB_En=1, FORWARDING_EN undefined -> hazard_stall=1, MEM_W_En=0. JMP with src1 matching EXE_Dest -> no stall, Br_taken=1.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: register file with same-cycle writeback bypass, decoder, branch resolution and hazard detection.
// Optional macro FORWARDING_EN reduces the hazard check to load-use only (EXE load feeding a used source).
module id_stage #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       Instruction,
  input  logic              WB_En_in,
  input  logic [4:0]        WB_Dest_in,
  input  logic [DATA_W-1:0] WB_Value,
  input  logic [4:0]        EXE_Dest,
  input  logic              EXE_WB_En,
  input  logic              EXE_MEM_R_En,
  input  logic [4:0]        MEM_Dest,
  input  logic              MEM_WB_En,
  output logic [DATA_W-1:0] Val1,
  output logic [DATA_W-1:0] Val2,
  output logic [DATA_W-1:0] Reg2,
  output logic [4:0]        Dest,
  output logic [4:0]        Src1,
  output logic [4:0]        Src2,
  output logic [3:0]        EXE_CMD,
  output logic              MEM_R_En,
  output logic              MEM_W_En,
  output logic              WB_En,
  output logic              Br_taken,
  output logic [31:0]       Br_target,
  output logic              hazard_stall
);

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  logic [5:0]  op;
  logic [4:0]  dest_f;
  logic [4:0]  src1_f;
  logic [4:0]  src2_f;
  logic [15:0] imm_f;

  assign op     = Instruction[31:26];
  assign dest_f = Instruction[25:21];
  assign src1_f = Instruction[20:16];
  assign src2_f = Instruction[15:11];
  assign imm_f  = Instruction[15:0];

  // Register file; entry 0 is never written and its reads are forced to zero.
  logic [DATA_W-1:0] rf_q [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (WB_En_in && (WB_Dest_in != 5'd0)) begin
      rf_q[WB_Dest_in] <= WB_Value;
    end
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] addr);
    if (addr == 5'd0)                          return '0;
    else if (WB_En_in && (WB_Dest_in == addr)) return WB_Value;
    else                                       return rf_q[addr];
  endfunction

  logic [3:0] cmd;
  logic       is_rtype, wb_dec, mr_dec, mw_dec;
  logic       use_src1, use_src2, port2_dest;
  logic       is_bez, is_bne, is_jmp;

  always_comb begin
    cmd        = 4'b0000;
    is_rtype   = 1'b0;
    wb_dec     = 1'b0;
    mr_dec     = 1'b0;
    mw_dec     = 1'b0;
    use_src1   = 1'b0;
    use_src2   = 1'b0;
    port2_dest = 1'b0;
    is_bez     = 1'b0;
    is_bne     = 1'b0;
    is_jmp     = 1'b0;
    case (op)
      OP_ADD:          begin is_rtype = 1'b1; cmd = 4'b0000; end
      OP_SUB:          begin is_rtype = 1'b1; cmd = 4'b0010; end
      OP_AND:          begin is_rtype = 1'b1; cmd = 4'b0100; end
      OP_OR:           begin is_rtype = 1'b1; cmd = 4'b0101; end
      OP_NOR:          begin is_rtype = 1'b1; cmd = 4'b0110; end
      OP_XOR:          begin is_rtype = 1'b1; cmd = 4'b0111; end
      OP_SLA, OP_SLL:  begin is_rtype = 1'b1; cmd = 4'b1000; end
      OP_SRA:          begin is_rtype = 1'b1; cmd = 4'b1001; end
      OP_SRL:          begin is_rtype = 1'b1; cmd = 4'b1010; end
      OP_ADDI:         begin wb_dec = 1'b1; use_src1 = 1'b1; cmd = 4'b0000; end
      OP_SUBI:         begin wb_dec = 1'b1; use_src1 = 1'b1; cmd = 4'b0010; end
      OP_LD:           begin wb_dec = 1'b1; mr_dec = 1'b1; use_src1 = 1'b1; end
      OP_ST:           begin mw_dec = 1'b1; use_src1 = 1'b1; use_src2 = 1'b1; port2_dest = 1'b1; end
      OP_BEZ:          begin is_bez = 1'b1; use_src1 = 1'b1; end
      OP_BNE:          begin is_bne = 1'b1; use_src1 = 1'b1; use_src2 = 1'b1; port2_dest = 1'b1; end
      OP_JMP:          is_jmp = 1'b1;
      default:         ;
    endcase
    if (is_rtype) begin
      wb_dec   = 1'b1;
      use_src1 = 1'b1;
      use_src2 = 1'b1;
    end
  end

  logic [4:0]        p2_addr;
  logic [DATA_W-1:0] rd1, rd2;
  logic              br_raw;

  assign p2_addr = port2_dest ? dest_f : src2_f;
  assign rd1     = rf_read(src1_f);
  assign rd2     = rf_read(p2_addr);
  assign br_raw  = (is_bez && (rd1 == '0)) || (is_bne && (rd1 != rd2)) || is_jmp;

  function automatic logic src_hit(input logic used, input logic [4:0] addr);
`ifdef FORWARDING_EN
    return used && (addr != 5'd0) && EXE_MEM_R_En && (addr == EXE_Dest);
`else
    return used && (addr != 5'd0) &&
           ((EXE_WB_En && (addr == EXE_Dest)) || (MEM_WB_En && (addr == MEM_Dest)));
`endif
  endfunction

`ifdef FORWARDING_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{EXE_WB_En, MEM_WB_En, MEM_Dest};
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = EXE_MEM_R_En;
`endif

  logic hz, issue_ok;
  assign hz       = src_hit(use_src1, src1_f) || src_hit(use_src2, p2_addr);
  // A stall turns this slot into a bubble: side effects are suppressed, datapath stays valid.
  assign issue_ok = !rst && !hz;

  assign Val1         = rd1;
  assign Reg2         = rd2;
  assign Val2         = is_rtype ? rd2 : {{(DATA_W-16){imm_f[15]}}, imm_f};
  assign Dest         = dest_f;
  assign Src1         = src1_f;
  assign Src2         = p2_addr;
  assign Br_target    = PC_in + {{16{imm_f[15]}}, imm_f};
  assign EXE_CMD      = rst ? 4'b0000 : cmd;
  assign WB_En        = issue_ok && wb_dec;
  assign MEM_R_En     = issue_ok && mr_dec;
  assign MEM_W_En     = issue_ok && mw_dec;
  assign Br_taken     = issue_ok && br_raw;
  assign hazard_stall = !rst && hz;

endmodule
